// File: rtl/bk_pkg.sv
// Shared constants for the breakdown feedback monitor: default measurement
// windows, error-bit positions and the monitor state encoding.
`timescale 1ns/1ps
package bk_pkg;

  localparam int DEF_W_MIN   = 800;
  localparam int DEF_W_MAX   = 950;
  localparam int DEF_P_MIN   = 240000;
  localparam int DEF_P_MAX   = 260000;
  localparam int DEF_TIMEOUT = 500000;

  localparam logic [1:0] ERR_WIDTH   = 2'd0;
  localparam logic [1:0] ERR_PERIOD  = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } bk_state_e;

endpackage

// File: rtl/bk_sync_edge.sv
// Two-flop synchroniser for an asynchronous level plus an edge register;
// rise/fall are decoded from the synchronised level.
`timescale 1ns/1ps
module bk_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d_async,
  output logic rise,
  output logic fall
);

  logic meta_r;
  logic sync_r;
  logic prev_r;

  // synchroniser chain and previous-level register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
      prev_r <= 1'b0;
    end else begin
      meta_r <= d_async;
      sync_r <= meta_r;
      prev_r <= sync_r;
    end
  end

  assign rise = sync_r & ~prev_r;
  assign fall = ~sync_r & prev_r;

endmodule

// File: rtl/bk_pulse_monitor.sv
// Breakdown feedback monitor: measures high width and rise-to-rise period of the
// synchronised pulse train and flags out-of-window, stuck-high and timeout faults.
`timescale 1ns/1ps
module bk_pulse_monitor
  import bk_pkg::*;
#(
  parameter int CNT_W   = 20,
  parameter int W_MIN   = DEF_W_MIN,
  parameter int W_MAX   = DEF_W_MAX,
  parameter int P_MIN   = DEF_P_MIN,
  parameter int P_MAX   = DEF_P_MAX,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int OK_CNT  = 4
) (
  input  logic             i_clk_25m,
  input  logic             i_rst,
  input  logic             i_bk_pulse,
  input  logic             i_err_clr,
  output logic             o_meas_valid,
  output logic [CNT_W-1:0] o_width,
  output logic [CNT_W-1:0] o_period,
  output logic             o_bk_ok,
  output logic [2:0]       o_err
);

  localparam int               GW        = $clog2(OK_CNT + 1);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);
  localparam logic [CNT_W-1:0] SAT_C     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] W_MIN_C   = CNT_W'(W_MIN);
  localparam logic [CNT_W-1:0] W_MAX_C   = CNT_W'(W_MAX);
  localparam logic [CNT_W-1:0] W_STUCK_C = CNT_W'(W_MAX + 1);
  localparam logic [CNT_W-1:0] P_MIN_C   = CNT_W'(P_MIN);
  localparam logic [CNT_W-1:0] P_MAX_C   = CNT_W'(P_MAX);
  localparam logic [CNT_W-1:0] TO_C      = CNT_W'(TIMEOUT);
  localparam logic [GW-1:0]    OK_C      = GW'(OK_CNT);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == SAT_C) ? v : v + ONE_C;
  endfunction

  // A saturated count means the true value is unknown, so it never passes.
  function automatic logic in_win(input logic [CNT_W-1:0] v,
                                  input logic [CNT_W-1:0] lo,
                                  input logic [CNT_W-1:0] hi);
    return (v != SAT_C) && (v >= lo) && (v <= hi);
  endfunction

  logic             rise_s, fall_s;
  bk_state_e        state_r, state_nx_s;
  logic [CNT_W-1:0] width_cnt_r, width_nx_s;
  logic [CNT_W-1:0] width_lat_r, wlat_nx_s;
  logic [CNT_W-1:0] period_cnt_r, period_nx_s;
  logic [CNT_W-1:0] to_cnt_r, to_nx_s;
  logic [GW-1:0]    good_cnt_r, good_nx_s;
  logic             report_s, clr_good_s, good_pulse_s;
  logic [2:0]       err_set_s;
  logic             meas_valid_r, bk_ok_r;
  logic [CNT_W-1:0] width_r, period_r;
  logic [2:0]       err_r;

  bk_sync_edge u_sync (
    .clk     (i_clk_25m),
    .rst     (i_rst),
    .d_async (i_bk_pulse),
    .rise    (rise_s),
    .fall    (fall_s)
  );

  // next-state, counter and error-set decode
  always_comb begin
    state_nx_s   = state_r;
    width_nx_s   = width_cnt_r;
    wlat_nx_s    = width_lat_r;
    period_nx_s  = rise_s ? ONE_C : sat_inc(period_cnt_r);
    to_nx_s      = rise_s ? ONE_C : sat_inc(to_cnt_r);
    report_s     = 1'b0;
    clr_good_s   = 1'b0;
    err_set_s    = 3'b000;
    good_pulse_s = in_win(width_lat_r, W_MIN_C, W_MAX_C) &&
                   in_win(period_cnt_r, P_MIN_C, P_MAX_C);
    good_nx_s    = good_cnt_r;

    case (state_r)
      S_WAIT: begin
        if (rise_s) begin
          state_nx_s = S_HIGH;
          width_nx_s = ONE_C;
        end else begin
          state_nx_s = S_WAIT;
        end
      end
      S_HIGH: begin
        width_nx_s = sat_inc(width_cnt_r);
        // stuck-high is flagged once, the cycle the width first exceeds the window
        if (width_cnt_r == W_STUCK_C) begin
          err_set_s[ERR_WIDTH] = 1'b1;
          clr_good_s           = 1'b1;
        end else begin
          clr_good_s = 1'b0;
        end
        if (fall_s) begin
          wlat_nx_s  = width_cnt_r;
          state_nx_s = S_LOW;
        end else begin
          state_nx_s = S_HIGH;
        end
      end
      S_LOW: begin
        if (rise_s) begin
          state_nx_s            = S_HIGH;
          width_nx_s            = ONE_C;
          report_s              = 1'b1;
          err_set_s[ERR_WIDTH]  = !in_win(width_lat_r, W_MIN_C, W_MAX_C);
          err_set_s[ERR_PERIOD] = !in_win(period_cnt_r, P_MIN_C, P_MAX_C);
        end else begin
          state_nx_s = S_LOW;
        end
      end
      default: state_nx_s = S_WAIT;
    endcase

    if (!rise_s && (to_cnt_r == TO_C)) begin
      err_set_s[ERR_TIMEOUT] = 1'b1;
      clr_good_s             = 1'b1;
      state_nx_s             = S_WAIT;
    end else begin
      err_set_s[ERR_TIMEOUT] = 1'b0;
    end

    if (clr_good_s) begin
      good_nx_s = {GW{1'b0}};
    end else if (report_s && good_pulse_s) begin
      good_nx_s = (good_cnt_r == OK_C) ? good_cnt_r : good_cnt_r + GW'(1);
    end else if (report_s) begin
      good_nx_s = {GW{1'b0}};
    end else begin
      good_nx_s = good_cnt_r;
    end
  end

  // state, counters and registered outputs
  always_ff @(posedge i_clk_25m or posedge i_rst) begin
    if (i_rst) begin
      state_r      <= S_WAIT;
      width_cnt_r  <= {CNT_W{1'b0}};
      width_lat_r  <= {CNT_W{1'b0}};
      period_cnt_r <= {CNT_W{1'b0}};
      to_cnt_r     <= {CNT_W{1'b0}};
      good_cnt_r   <= {GW{1'b0}};
      meas_valid_r <= 1'b0;
      width_r      <= {CNT_W{1'b0}};
      period_r     <= {CNT_W{1'b0}};
      bk_ok_r      <= 1'b0;
      err_r        <= 3'b000;
    end else begin
      state_r      <= state_nx_s;
      width_cnt_r  <= width_nx_s;
      width_lat_r  <= wlat_nx_s;
      period_cnt_r <= period_nx_s;
      to_cnt_r     <= to_nx_s;
      good_cnt_r   <= good_nx_s;
      meas_valid_r <= report_s;
      if (report_s) begin
        width_r  <= width_lat_r;
        period_r <= period_cnt_r;
      end
      bk_ok_r <= (good_nx_s == OK_C);
      // a bit set this cycle survives a simultaneous clear
      err_r   <= (i_err_clr ? 3'b000 : err_r) | err_set_s;
    end
  end

  assign o_meas_valid = meas_valid_r;
  assign o_width      = width_r;
  assign o_period     = period_r;
  assign o_bk_ok      = bk_ok_r;
  assign o_err        = err_r;

endmodule
